// File: rtl/mc8051_mc_sequencer_pkg.sv
// Shared constants for the mc8051 microcode sequencer:
// phase encodings, microcode word layout and IRQ entry opcode.
package mc8051_mc_sequencer_pkg;

  typedef logic [3:0] phase_t;

  localparam int MC_WORD_W    = 64;
  localparam int MC_MULTI_BIT = 63;

  localparam phase_t PH_IDLE = 4'd0;
  localparam phase_t PH_S1   = 4'd1;
  localparam phase_t PH_S2   = 4'd2;
  localparam phase_t PH_S3   = 4'd3;
  localparam phase_t PH_S4   = 4'd4;
  localparam phase_t PH_S5   = 4'd5;
  localparam phase_t PH_S6   = 4'd6;

  localparam logic [7:0] MC_IRQ_OPCODE = 8'hA5;
  localparam logic [1:0] MC_MAX_CYCLE  = 2'd3;

  function automatic phase_t ph_next(input phase_t ph);
    return ph + 4'd1;
  endfunction

endpackage

// File: rtl/mc8051_mc_sequencer_rom.sv
// Microcode ROM: synchronous read with enable and a
// resettable output register (reset value is the NOP word).
module mc8051_mc_sequencer_rom #(
  parameter int    MCODE_WIDTH  = 64,
  parameter int    MC_ADDR_W    = 10,
  parameter string MC_INIT_FILE = "mc8051_mc.hex"
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rd_en_i,
  input  logic [MC_ADDR_W-1:0]   addr_i,
  output logic [MCODE_WIDTH-1:0] data_o
);

  localparam int DEPTH = 1 << MC_ADDR_W;

  logic [MCODE_WIDTH-1:0] mem_q [DEPTH];
  logic [MCODE_WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else if (rd_en_i) begin
      data_q <= mem_q[addr_i];
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/mc8051_mc_sequencer.sv
// mc8051 microcode sequencer: S1..S6 phase FSM, opcode/IRQ
// issue, multi-cycle walk through the microcode ROM.
module mc8051_mc_sequencer #(
  parameter int    MCODE_WIDTH  = 64,
  parameter int    MC_ADDR_W    = 10,
  parameter string MC_INIT_FILE = "mc8051_mc.hex"
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             i_opcode,
  input  logic                   i_op_valid,
  output logic                   o_op_ready,
  input  logic                   i_irq_req,
  output logic                   o_irq_ack,
  input  logic                   i_stall,
  output logic [MCODE_WIDTH-1:0] o_mc_b,
  output logic [3:0]             o_t_p_q,
  output logic [3:0]             o_t_p_d,
  output logic [MC_ADDR_W-1:0]   o_mc_addr,
  output logic                   o_insn_done
);

  import mc8051_mc_sequencer_pkg::*;

  phase_t               state_q, state_d;
  logic [1:0]           cyc_q, cyc_d;
  logic [7:0]           opc_q, opc_d;
  logic [MC_ADDR_W-1:0] addr_q, addr_d;
  logic                 s6_go, last_cyc, issue;
  logic                 irq_take, op_take, multi, rd_en;

  assign last_cyc = !o_mc_b[MC_MULTI_BIT]
                 || cyc_q == MC_MAX_CYCLE;
  assign s6_go    = !reset && state_q == PH_S6 && !i_stall;
  assign issue    = (!reset && state_q == PH_IDLE)
                 || (s6_go && last_cyc);

  // IRQ wins the issue slot; the pending opcode waits.
  assign irq_take    = issue && i_irq_req;
  assign o_op_ready  = issue && !i_irq_req;
  assign op_take     = o_op_ready && i_op_valid;
  assign multi       = s6_go && !last_cyc;
  assign rd_en       = irq_take || op_take || multi;
  assign o_irq_ack   = irq_take;
  assign o_insn_done = s6_go && last_cyc;

  always_comb begin
    cyc_d  = cyc_q;
    opc_d  = opc_q;
    addr_d = addr_q;
    unique case (1'b1)
      irq_take: begin
        opc_d  = MC_IRQ_OPCODE;
        cyc_d  = 2'd0;
        addr_d = {MC_IRQ_OPCODE, 2'b00};
      end
      op_take: begin
        opc_d  = i_opcode;
        cyc_d  = 2'd0;
        addr_d = {i_opcode, 2'b00};
      end
      multi: begin
        cyc_d  = cyc_q + 2'd1;
        addr_d = {opc_q, cyc_q + 2'd1};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (rd_en) begin
      state_d = PH_S1;
    end else if (s6_go) begin
      state_d = PH_IDLE;
    end else if (state_q != PH_IDLE && !i_stall) begin
      state_d = ph_next(state_q);
    end
    if (reset) begin
      state_d = PH_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PH_IDLE;
      cyc_q   <= 2'd0;
      opc_q   <= 8'd0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      opc_q   <= opc_d;
      addr_q  <= addr_d;
    end
  end

  mc8051_mc_sequencer_rom #(
    .MCODE_WIDTH (MCODE_WIDTH),
    .MC_ADDR_W   (MC_ADDR_W),
    .MC_INIT_FILE(MC_INIT_FILE)
  ) u_rom (
    .clk    (clk),
    .reset  (reset),
    .rd_en_i(rd_en),
    .addr_i (addr_d),
    .data_o (o_mc_b)
  );

  assign o_t_p_q   = state_q;
  assign o_t_p_d   = state_d;
  assign o_mc_addr = addr_q;

endmodule
